// File: rtl/reg_map_pkg.sv
// reg_map_pkg
// Shared definitions for the synth register write path: register addresses,
// reset values, the frequency-lock FSM encoding, and a small address helper.
// Status lives at 0x01. It is read-only, so it has no write address here.
package reg_map_pkg;

    localparam logic [7:0] REG_ADDR_CONTROL   = 8'h00;
    localparam logic [7:0] REG_ADDR_FREQ_LOW  = 8'h02;
    localparam logic [7:0] REG_ADDR_FREQ_MID  = 8'h03;
    localparam logic [7:0] REG_ADDR_FREQ_HIGH = 8'h04;
    localparam logic [7:0] REG_ADDR_DUTY      = 8'h05;
    localparam logic [7:0] REG_ADDR_VOLUME    = 8'h06;

    // Every writable register comes out of reset as zero.
    localparam logic [7:0] REG_RESET_VAL = 8'h00;

    // The round-robin pointer records the last winner. Starting it at B
    // means requester A is favoured on the first contested cycle.
    localparam logic RR_RESET_LAST_B = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_A = 2'd1,
        ARB_LOCK_B = 2'd2
    } arb_state_t;

    // The low and mid frequency bytes are the ones staged ahead of a commit.
    function automatic logic is_shadow_addr(input logic [7:0] addr);
        return (addr == REG_ADDR_FREQ_LOW) || (addr == REG_ADDR_FREQ_MID);
    endfunction

endpackage

// File: rtl/reg_arb_rr2.sv
// reg_arb_rr2
// Two-requester round-robin grant. The grant is combinational from the
// requests and the stored last-winner pointer. The pointer moves to the
// winner whenever a grant is issued while enable is high.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   enable            arbitration active (pointer may update)
//   req_a, req_b      requests
//   grant_a, grant_b  one-hot (or zero) grant
module reg_arb_rr2 (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b
);
    import reg_map_pkg::*;

    logic last_b;

    // A lone requester always wins. On a tie, the requester that did not
    // win last time gets the grant, so neither side can be starved.
    always_comb begin
        grant_a = req_a & (~req_b | last_b);
        grant_b = req_b & (~req_a | ~last_b);
    end

    // The pointer only tracks grants that were issued while enabled. While
    // the top is holding a lock, the pointer stays on the lock owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= RR_RESET_LAST_B;
        end else if (enable && (grant_a || grant_b)) begin
            last_b <= grant_b;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Arbitrates single-byte register writes from requester A (UART decoder)
// and requester B (preset/envelope sequencer). It also holds the committed
// register values.
// Optional feature macro REG_ARB_ATOMIC_FREQ_EN:
//   When defined, low and mid frequency bytes are staged in a shadow. The
//   first writer of a staged byte owns the frequency until it writes
//   freq_high, which commits all three bytes in one edge. Ownership is
//   dropped after LOCK_TIMEOUT idle cycles.
//   When undefined, frequency bytes are written straight to the outputs.
// Ports:
//   clk, rst_n                               clock, async active-low reset
//   a_valid/a_ready/a_addr/a_data            requester A write channel
//   b_valid/b_ready/b_addr/b_data            requester B write channel
//   status_gate_active, status_osc_running   live status inputs
//   reg_control .. reg_volume                committed register values
//   reg_status                               live status byte (combinational)
//   freq_update                              pulse after a frequency change
//   wr_err                                   pulse after a write to an unwritable address
//   lock_timeout                             pulse when a frequency lock is abandoned
module reg_write_arbiter #(
    parameter int LOCK_TIMEOUT = 65535,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_data,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_data,
    input  logic       status_gate_active,
    input  logic       status_osc_running,
    output logic [7:0] reg_control,
    output logic [7:0] reg_freq_low,
    output logic [7:0] reg_freq_mid,
    output logic [7:0] reg_freq_high,
    output logic [7:0] reg_duty,
    output logic [7:0] reg_volume,
    output logic [7:0] reg_status,
    output logic       freq_update,
    output logic       wr_err,
    output logic       lock_timeout
);
    import reg_map_pkg::*;

    logic       arb_enable;
    logic       grant_a;
    logic       grant_b;
    logic       a_fire;
    logic       b_fire;
    logic       wr_fire;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    // This block exists in the elaborated hierarchy only when the idle
    // counter is too narrow to reach the timeout value.
    if (LOCK_TIMEOUT - 1 > (1 << CNT_W) - 1) begin : g_cnt_w_too_narrow_for_lock_timeout
    end

    reg_arb_rr2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (arb_enable),
        .req_a   (a_valid),
        .req_b   (b_valid),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    assign reg_status = {6'b0, status_osc_running, status_gate_active};

    // At most one ready is high, so at most one side fires. The write bus
    // can therefore select B whenever B fires and A otherwise.
    assign a_fire  = a_valid & a_ready;
    assign b_fire  = b_valid & b_ready;
    assign wr_fire = a_fire | b_fire;
    assign wr_addr = b_fire ? b_data_sel_addr() : a_addr;
    assign wr_data = b_fire ? b_data : a_data;

    function automatic logic [7:0] b_data_sel_addr();
        return b_addr;
    endfunction

`ifdef REG_ARB_ATOMIC_FREQ_EN

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    arb_state_t       state;
    logic [7:0]       shadow_low;
    logic [7:0]       shadow_mid;
    logic [CNT_W-1:0] idle_cnt;

    assign arb_enable = (state == ARB_IDLE);

    // In IDLE the round-robin decides the grant. During a lock, only the
    // owner is let through, and the other side stalls until the owner
    // commits or times out.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                a_ready = grant_a;
                b_ready = grant_b;
            end
            ARB_LOCK_A: a_ready = a_valid;
            ARB_LOCK_B: b_ready = b_valid;
            default: ;
        endcase
    end

    // Register bank, shadow, lock FSM and pulse outputs.
    // Staged bytes go only to the shadow. A freq_high write copies the
    // shadow and the new high byte to the outputs together, so the
    // oscillator never sees a half-updated frequency word.
    // An accepted write always clears the idle counter. The timeout branch
    // is therefore only reached on cycles where the owner did not write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARB_IDLE;
            idle_cnt      <= '0;
            shadow_low    <= REG_RESET_VAL;
            shadow_mid    <= REG_RESET_VAL;
            reg_control   <= REG_RESET_VAL;
            reg_freq_low  <= REG_RESET_VAL;
            reg_freq_mid  <= REG_RESET_VAL;
            reg_freq_high <= REG_RESET_VAL;
            reg_duty      <= REG_RESET_VAL;
            reg_volume    <= REG_RESET_VAL;
            freq_update   <= 1'b0;
            wr_err        <= 1'b0;
            lock_timeout  <= 1'b0;
        end else begin
            freq_update  <= 1'b0;
            wr_err       <= 1'b0;
            lock_timeout <= 1'b0;
            if (wr_fire) begin
                case (wr_addr)
                    REG_ADDR_CONTROL:  reg_control <= wr_data;
                    REG_ADDR_FREQ_LOW: shadow_low  <= wr_data;
                    REG_ADDR_FREQ_MID: shadow_mid  <= wr_data;
                    REG_ADDR_FREQ_HIGH: begin
                        reg_freq_high <= wr_data;
                        reg_freq_mid  <= shadow_mid;
                        reg_freq_low  <= shadow_low;
                        freq_update   <= 1'b1;
                    end
                    REG_ADDR_DUTY:     reg_duty    <= wr_data;
                    REG_ADDR_VOLUME:   reg_volume  <= wr_data;
                    default:           wr_err      <= 1'b1;
                endcase
                idle_cnt <= '0;
                if (state == ARB_IDLE) begin
                    if (is_shadow_addr(wr_addr)) begin
                        state <= b_fire ? ARB_LOCK_B : ARB_LOCK_A;
                    end
                end else if (wr_addr == REG_ADDR_FREQ_HIGH) begin
                    state <= ARB_IDLE;
                end
            end else if (state != ARB_IDLE) begin
                if (idle_cnt == TIMEOUT_LAST) begin
                    state        <= ARB_IDLE;
                    idle_cnt     <= '0;
                    shadow_low   <= reg_freq_low;
                    shadow_mid   <= reg_freq_mid;
                    lock_timeout <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

`else

    assign arb_enable   = 1'b1;
    assign a_ready      = grant_a;
    assign b_ready      = grant_b;
    assign lock_timeout = 1'b0;

    // Without atomic frequency updates, every write lands directly on its
    // register. A write to any of the three frequency bytes raises
    // freq_update on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_control   <= REG_RESET_VAL;
            reg_freq_low  <= REG_RESET_VAL;
            reg_freq_mid  <= REG_RESET_VAL;
            reg_freq_high <= REG_RESET_VAL;
            reg_duty      <= REG_RESET_VAL;
            reg_volume    <= REG_RESET_VAL;
            freq_update   <= 1'b0;
            wr_err        <= 1'b0;
        end else begin
            freq_update <= wr_fire &&
                           (is_shadow_addr(wr_addr) || wr_addr == REG_ADDR_FREQ_HIGH);
            wr_err      <= 1'b0;
            if (wr_fire) begin
                case (wr_addr)
                    REG_ADDR_CONTROL:   reg_control   <= wr_data;
                    REG_ADDR_FREQ_LOW:  reg_freq_low  <= wr_data;
                    REG_ADDR_FREQ_MID:  reg_freq_mid  <= wr_data;
                    REG_ADDR_FREQ_HIGH: reg_freq_high <= wr_data;
                    REG_ADDR_DUTY:      reg_duty      <= wr_data;
                    REG_ADDR_VOLUME:    reg_volume    <= wr_data;
                    default:            wr_err        <= 1'b1;
                endcase
            end
        end
    end

`endif

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Sits between the register write sources and the synth register bank (control, 24-bit frequency, duty, volume, status).
- Arbitrates single-byte register writes from two requesters: A (UART byte-pair decoder) and B (internal preset/envelope sequencer).
- Holds the register outputs itself.
- Guarantees the 24-bit frequency word updates atomically, so the oscillator never sees a mixed old/new value or bytes interleaved from two sources.

Parameters:
- LOCK_TIMEOUT, 65535: cycles of owner inactivity after which a frequency lock is abandoned.
- CNT_W, 16: width of the lock inactivity counter; must hold LOCK_TIMEOUT.

Ports:
- clk  in  1  system clock (50 MHz nominal).
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  requester A write accepted this cycle.
- a_addr  in  8  requester A register address.
- a_data  in  8  requester A write data.
- b_valid, b_ready, b_addr, b_data: as for requester A.
- status_gate_active  in  1  live gate status.
- status_osc_running  in  1  live oscillator status.
- reg_control, reg_freq_low, reg_freq_mid, reg_freq_high, reg_duty, reg_volume  out  8 each  committed register values.
- reg_status  out  8  {6'b0, status_osc_running, status_gate_active}, combinational, read-only.
- freq_update  out  1  one-cycle pulse the cycle after the committed frequency changes.
- wr_err  out  1  one-cycle pulse: accepted write to an unwritable address.
- lock_timeout  out  1  one-cycle pulse: frequency lock abandoned.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low. clk and rst_n are the only clock and reset.
- Reset values: all reg_* outputs 0x00 except reg_status; freq_update, wr_err and lock_timeout 0; FSM in IDLE; round-robin pointer favours A.
- Handshake:
  - A write transfers on a cycle with x_valid && x_ready.
  - x_ready is combinational from state, the valids and the RR pointer. At most one ready is high per cycle.
  - A requester holds addr/data stable while valid is high and not yet accepted.
- Address map:
  - 0x00 control; 0x02 freq_low; 0x03 freq_mid; 0x04 freq_high; 0x05 duty; 0x06 volume.
  - All other addresses, including status: write accepted and discarded, wr_err pulses next cycle.
- Latency: accepted write is visible on reg_* at the next rising edge.
- FSM states: IDLE, LOCK_A, LOCK_B.
- IDLE:
  - Only one valid high: grant it.
  - Both valid: grant the requester opposite the RR pointer. The pointer toggles to the winner on every IDLE grant.
  - An accepted write to 0x02 or 0x03 loads the shadow byte and moves to LOCK_<winner>.
- LOCK_x:
  - Only owner x can get ready; the other requester stalls with ready=0.
  - Owner write to 0x02 or 0x03 updates the shadow.
  - Owner write to 0x04 commits freq_high and both shadow bytes to the outputs in the same edge, then returns to IDLE with the pointer set to x.
  - Owner write to any other address is applied normally; lock is held.
- Inactivity counter:
  - Clears on entering a lock and on each owner accept; otherwise increments.
  - At LOCK_TIMEOUT-1 the FSM goes to IDLE, the shadow reloads from the committed bytes, and lock_timeout pulses.
- Write to 0x04 from IDLE: commits immediately using the current shadow, which equals the committed values unless set by a locked sequence.
- Simultaneous timeout and owner accept in the same cycle: the accept wins; the counter clears.
- Reset mid-lock: everything returns to reset values; the partial shadow is lost.

Optional Feature:
- Macro: REG_ARB_ATOMIC_FREQ_EN.
- Defined: shadow and lock behaviour as above.
- Undefined:
  - No LOCK states and no shadow; 0x02–0x04 write the outputs directly.
  - freq_update pulses after any frequency-byte write.
  - lock_timeout is tied to 0.
  - Arbitration is pure round-robin per write.

Decomposition:
- Package reg_map_pkg holds:
  - address localparams REG_ADDR_CONTROL … REG_ADDR_VOLUME;
  - reset values;
  - FSM state encoding for IDLE/LOCK_A/LOCK_B.
- One sub-module: reg_arb_rr2, a two-requester round-robin grant with pointer update, instantiated once.

Test Plan:
- A writes 0x00=0x1D, with B idle: a_ready is high in the same cycle; reg_control=0x1D on the next edge; wr_err=0.
- A and B both valid every cycle, writing 0x05=0x40 and 0x06=0x80 repeatedly: grants alternate A,B,A,B; after the first pair, reg_duty=0x40 and reg_volume=0x80.
- A writes 0x02=0x00 and 0x03=0x40 while B keeps requesting 0x02=0xAA; then A writes 0x04=0x02:
  - b_ready stays 0 throughout;
  - {high,mid,low}=0x024000 appears in one edge; freq_update pulses once;
  - B is then granted.
- A writes 0x02=0x55, then goes silent for LOCK_TIMEOUT cycles: lock_timeout pulses; committed frequency is unchanged; the next 0x04 write does not pick up 0x55.
- Writes to 0x07 and 0x12 with data 0xFF: wr_err pulses per write; no register changes; reg_status follows inputs (0x03 when both status inputs are 1).
- rst_n asserted during LOCK_B: all outputs read 0x00 immediately; after release, a lone A write is granted.
